demux_sched: RTL and testbench
==============================

DEMUX_SCHED -- requirements
Module: demux_sched

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum number of SCAN cycles spent waiting for an eligible lane (legal range 1..255).
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the statistics counters.
REQ-003 clk  input  1  single clock for all state; every register updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 a  input  1  data bit to be routed to one of 16 lanes.
REQ-006 in_valid  input  1  a is valid this cycle.
REQ-007 in_ready  output  1  block accepts a this cycle; a transfer occurs when in_valid and in_ready are both 1.
REQ-008 mode  input  1  sampled with a: 0 = round-robin lane choice, 1 = fixed lane given by addr.
REQ-009 addr  input  4  target lane for mode=1, sampled with a.
REQ-010 lane_en  input  16  static per-lane enable mask.
REQ-011 lane_ready  input  16  per-lane "can take a bit now".
REQ-012 sel  output  4  registered index of the lane being driven; holds its last value outside DELIVER.
REQ-013 y  output  16  routed data: y[sel]=captured bit during DELIVER; all other bits 0.
REQ-014 strb  output  16  one-hot delivery strobe, bit sel high for exactly one cycle.
REQ-015 busy  output  1  high in SCAN and DELIVER.
REQ-016 sent_cnt  output  CNT_W  count of delivered bits, saturating.
REQ-017 drop_cnt  output  CNT_W  count of bits dropped on timeout, saturating.

Function
REQ-018 The FSM SHALL have three states: IDLE, SCAN and DELIVER.
REQ-019 IDLE: in_ready SHALL equal (lane_en != 0); on a transfer, the block SHALL capture a, mode and addr, clear the wait counter and enter SCAN.
REQ-020 IDLE with lane_en == 0: in_ready SHALL be 0 and the state SHALL remain IDLE.
REQ-021 in_ready SHALL be 0 in SCAN and DELIVER; there are no back-to-back transfers, so the minimum period per bit is 3 cycles.
REQ-022 A lane k is eligible when lane_en[k] and lane_ready[k] are both 1, evaluated combinationally every SCAN cycle.
REQ-023 Round-robin (mode=0): the chosen lane SHALL be the first eligible lane searching ptr, ptr+1, ... 15, 0, ... ptr-1 (mod 16), resolved in one cycle.
REQ-024 Fixed (mode=1): the only candidate SHALL be the captured addr.
REQ-025 SCAN with a candidate found: on the next edge, sel SHALL take the chosen index and the state SHALL become DELIVER.
REQ-026 DELIVER (exactly one cycle): strb SHALL equal 1<<sel and y SHALL equal captured_bit<<sel.
REQ-027 DELIVER exit: on the next edge, the state SHALL return to IDLE, strb and y SHALL clear, and sent_cnt SHALL increment.
REQ-028 DELIVER exit in mode=0: ptr SHALL become sel+1 mod 16 (15 wraps to 0).
REQ-029 DELIVER exit in mode=1: ptr SHALL be unchanged.
REQ-030 Latency: strb SHALL rise 2 cycles after the acceptance edge when a lane is eligible on the first SCAN cycle.
REQ-031 SCAN with no candidate: the wait counter SHALL increment each cycle.
REQ-032 Timeout: if there is still no candidate in the cycle where the wait counter equals TIMEOUT-1, then on that edge the bit SHALL be discarded, drop_cnt SHALL increment, the state SHALL return to IDLE, and strb SHALL not be asserted.
REQ-033 A lane that becomes ready in the last SCAN cycle (wait counter = TIMEOUT-1) SHALL win over the timeout.
REQ-034 Changes to lane_en or lane_ready during SCAN SHALL take effect on the same cycle's evaluation.
REQ-035 Changes to lane_en or lane_ready during DELIVER SHALL be ignored.
REQ-036 Counters SHALL saturate at all-ones and never wrap.
REQ-037 strb SHALL never have more than one bit set.

Reset
REQ-038 Reset asserted SHALL immediately, without waiting for clk, force: state=IDLE, ptr=0, sel=0, y=0, strb=0, busy=0, sent_cnt=0, drop_cnt=0, wait counter=0.
REQ-039 Reset asserted mid-SCAN or mid-DELIVER SHALL discard the in-flight bit with no strb and no counter change.
REQ-040 in_ready SHALL be 0 while rst=1 and SHALL follow REQ-019/REQ-020 from the first edge after release.

Verification
REQ-041 lane_en=FFFF, lane_ready=FFFF, mode=0; send bits 1,0,1 -> strb=0001, 0002, 0004 in turn; y=0001, 0000, 0004; sent_cnt=3.
REQ-042 lane_en=8001, ptr=15, all lanes ready, mode=0 -> delivery on lane 15 (strb=8000), then the next bit goes to lane 0 (wrap), then lane 15 again.
REQ-043 mode=1, addr=9, a=1, lane_ready[9]=0 for 5 cycles then 1 -> strb=0200 exactly 7 cycles after acceptance; ptr unchanged.
REQ-044 TIMEOUT=4, lane_ready=0000 -> after exactly 4 SCAN cycles, IDLE with drop_cnt=1, strb never set; repeat with ready rising in SCAN cycle 4 -> delivered, drop_cnt unchanged.
REQ-045 Assert rst asynchronously during DELIVER -> strb and y drop to 0 before the next edge; all counters 0; next bit goes to lane 0.
REQ-046 CNT_W=2; deliver 5 bits -> sent_cnt holds at 3; lane_en=0000 -> in_ready=0 and in_valid is ignored indefinitely.

Source files
------------

// File: rtl/demux_sched.sv
// -----------------------------------------------------------------------------
// demux_sched
//   Routes single data bits to one of 16 output lanes. Each accepted bit is
//   held while the scheduler looks for an eligible lane (enabled and ready).
//   The lane is chosen either round-robin from a rotating pointer or fixed by
//   the address sampled with the bit. A bit that finds no lane within TIMEOUT
//   scan cycles is dropped. Delivered and dropped bits are counted in
//   saturating counters.
//
// Parameters
//   TIMEOUT     maximum scan cycles spent waiting for a lane (1..255)
//   CNT_W       width of the statistics counters
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         asynchronous active-high reset
//   a           data bit to route
//   in_valid    a is valid this cycle
//   in_ready    block accepts a this cycle (transfer = in_valid & in_ready)
//   mode        sampled with a: 0 = round-robin, 1 = fixed lane addr
//   addr        target lane for mode=1, sampled with a
//   lane_en     static per-lane enable mask
//   lane_ready  per-lane "can take a bit now"
//   sel         index of the lane being driven, holds outside delivery
//   y           routed data, only bit sel may be set, during delivery
//   strb        one-hot delivery strobe, one cycle per delivered bit
//   busy        high while a bit is in flight (scan or delivery)
//   sent_cnt    delivered-bit count, saturating
//   drop_cnt    timed-out-bit count, saturating
// -----------------------------------------------------------------------------
module demux_sched #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [3:0]       addr,
  input  logic [15:0]      lane_en,
  input  logic [15:0]      lane_ready,
  output logic [3:0]       sel,
  output logic [15:0]      y,
  output logic [15:0]      strb,
  output logic             busy,
  output logic [CNT_W-1:0] sent_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_DELIVER = 2'd2
  } state_t;

  // Wait-counter value of the final scan cycle before the bit is dropped.
  localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

  state_t             r_state;
  state_t             w_next;

  logic               r_bit;
  logic               r_mode;
  logic [3:0]         r_addr;
  logic [7:0]         r_wait;
  logic [3:0]         r_ptr;
  logic [3:0]         r_sel;
  logic [15:0]        r_y;
  logic [15:0]        r_strb;
  logic [CNT_W-1:0]   r_sent;
  logic [CNT_W-1:0]   r_drop;

  logic [15:0]        w_elig;
  logic               w_found;
  logic [3:0]         w_pick;
  logic               w_xfer;
  logic               w_idle_rdy;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // First eligible lane starting at ptr and wrapping through 15 -> 0.
  // Returns {found, index}.
  function automatic logic [4:0] rr_pick(input logic [15:0] elig,
                                         input logic [3:0]  ptr);
    logic       found;
    logic [3:0] idx;
    logic [3:0] pick;
    found = 1'b0;
    pick  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      idx = ptr + 4'(i);
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return {found, pick};
  endfunction

  // Lane eligibility follows lane_en/lane_ready live during scan; the choice
  // is latched into sel/strb/y on the scan->deliver edge, so changes while
  // delivering have no effect.
  always_comb begin
    w_elig  = lane_en & lane_ready;
    w_found = 1'b0;
    w_pick  = 4'd0;
    if (r_mode) begin
      w_found = w_elig[r_addr];
      w_pick  = r_addr;
    end else begin
      {w_found, w_pick} = rr_pick(w_elig, r_ptr);
    end
  end

  // in_ready is gated by rst so nothing is accepted while reset is held.
  assign w_idle_rdy = (r_state == ST_IDLE) && (lane_en != 16'h0000) && !rst;
  assign w_xfer     = in_valid && w_idle_rdy;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          w_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // A lane found in the last scan cycle wins over the timeout.
        if (w_found) begin
          w_next = ST_DELIVER;
        end else if (r_wait == LP_WAIT_LAST) begin
          w_next = ST_IDLE;
        end
      end
      ST_DELIVER: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Captured bit and routing request; only meaningful once a transfer has
  // happened, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_bit  <= a;
      r_mode <= mode;
      r_addr <= addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait <= 8'd0;
      r_ptr  <= 4'd0;
      r_sel  <= 4'd0;
      r_y    <= 16'h0000;
      r_strb <= 16'h0000;
      r_sent <= '0;
      r_drop <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_wait <= 8'd0;
          end
        end
        ST_SCAN: begin
          if (w_found) begin
            r_sel  <= w_pick;
            r_strb <= 16'h0001 << w_pick;
            r_y    <= {15'h0000, r_bit} << w_pick;
          end else if (r_wait == LP_WAIT_LAST) begin
            r_drop <= sat_inc(r_drop);
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        ST_DELIVER: begin
          r_strb <= 16'h0000;
          r_y    <= 16'h0000;
          r_sent <= sat_inc(r_sent);
          // Fixed-lane deliveries leave the round-robin pointer alone.
          if (!r_mode) begin
            r_ptr <= r_sel + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready = w_idle_rdy;
  assign busy     = (r_state != ST_IDLE);
  assign sel      = r_sel;
  assign y        = r_y;
  assign strb     = r_strb;
  assign sent_cnt = r_sent;
  assign drop_cnt = r_drop;

endmodule

// File: tb/tb_demux_sched.sv
module tb_demux_sched;

  logic        clk;
  logic        rst;
  logic        a_i          [2];
  logic        in_valid_i   [2];
  logic        mode_i       [2];
  logic [3:0]  addr_i       [2];
  logic [15:0] lane_en_i    [2];
  logic [15:0] lane_ready_i [2];

  logic        rdy0, rdy1, busy0, busy1;
  logic [3:0]  sel0, sel1;
  logic [15:0] y0, y1, strb0, strb1;
  logic [7:0]  sent0, drop0;
  logic [1:0]  sent1, drop1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] s;
    logic [15:0] y;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Instance 0: default TIMEOUT, 8-bit counters.
  demux_sched #(.TIMEOUT(16), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .a(a_i[0]), .in_valid(in_valid_i[0]),
    .in_ready(rdy0), .mode(mode_i[0]), .addr(addr_i[0]),
    .lane_en(lane_en_i[0]), .lane_ready(lane_ready_i[0]),
    .sel(sel0), .y(y0), .strb(strb0), .busy(busy0),
    .sent_cnt(sent0), .drop_cnt(drop0)
  );

  // Instance 1: short timeout, 2-bit counters.
  demux_sched #(.TIMEOUT(4), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .a(a_i[1]), .in_valid(in_valid_i[1]),
    .in_ready(rdy1), .mode(mode_i[1]), .addr(addr_i[1]),
    .lane_en(lane_en_i[1]), .lane_ready(lane_ready_i[1]),
    .sel(sel1), .y(y1), .strb(strb1), .busy(busy1),
    .sent_cnt(sent1), .drop_cnt(drop1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] f_strb(input int d);
    return (d == 0) ? strb0 : strb1;
  endfunction

  function automatic logic f_rdy(input int d);
    return (d == 0) ? rdy0 : rdy1;
  endfunction

  function automatic logic f_busy(input int d);
    return (d == 0) ? busy0 : busy1;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push(input int d, input logic [15:0] s, input logic [15:0] yv);
    exp_t e;
    e.s = s;
    e.y = yv;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Scoreboard monitor: every cycle with a strobe must match the oldest
  // expected delivery of that instance.
  task automatic mon_one(input int d, input logic [15:0] s, input logic [15:0] yv);
    exp_t e;
    if (s != 16'h0000) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        check($sformatf("strb_unexpected%0d", d), {16'h0, s}, 32'h0);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("strb%0d", d), {16'h0, s}, {16'h0, e.s});
        check($sformatf("y%0d", d), {16'h0, yv}, {16'h0, e.y});
      end
    end
  endtask

  always @(negedge clk) begin
    mon_one(0, strb0, y0);
    mon_one(1, strb1, y1);
  end

  // Waits (bounded) for in_ready, presents one bit for one cycle and returns
  // 1 time unit after the acceptance edge.
  task automatic send(input int d, input logic b, input logic m, input logic [3:0] ad);
    int n;
    n = 0;
    @(negedge clk);
    while (!f_rdy(d) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!f_rdy(d)) begin
      check("accept_wait", 32'h0, 32'h1);
      return;
    end
    a_i[d]        = b;
    mode_i[d]     = m;
    addr_i[d]     = ad;
    in_valid_i[d] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_i[d] = 1'b0;
    check("busy_after_accept", {31'h0, f_busy(d)}, 32'h1);
    check("ready_after_accept", {31'h0, f_rdy(d)}, 32'h0);
  endtask

  // Counts cycles from acceptance (acceptance cycle = 0) until strb is seen.
  // Optionally changes lane_ready right after the edge ending cycle set_at.
  task automatic wait_strb(input int d, input int set_at, input logic [15:0] rdy,
                           input int exp_lat, input string nm);
    int lat;
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (f_strb(d) != 16'h0000) begin
        lat = c;
        break;
      end
      if (c == set_at) begin
        @(posedge clk);
        #1;
        lane_ready_i[d] = rdy;
      end
    end
    check(nm, lat, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      a_i[d]          = 1'b0;
      in_valid_i[d]   = 1'b0;
      mode_i[d]       = 1'b0;
      addr_i[d]       = 4'd0;
      lane_en_i[d]    = 16'hFFFF;
      lane_ready_i[d] = 16'hFFFF;
    end
    repeat (3) @(negedge clk);

    // Reset state, in_ready low while rst is held
    check("rst_in_ready0", {31'h0, rdy0}, 32'h0);
    check("rst_in_ready1", {31'h0, rdy1}, 32'h0);
    check("rst_busy", {31'h0, busy0}, 32'h0);
    check("rst_sel", {28'h0, sel0}, 32'h0);
    check("rst_strb", {16'h0, strb0}, 32'h0);
    check("rst_y", {16'h0, y0}, 32'h0);
    check("rst_sent", {24'h0, sent0}, 32'h0);
    check("rst_drop", {24'h0, drop0}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'h0, rdy0}, 32'h1);

    // Round-robin over all lanes: bits 1,0,1 -> lanes 0,1,2
    push(0, 16'h0001, 16'h0001); send(0, 1'b1, 1'b0, 4'd0);
    wait_strb(0, 0, 16'hFFFF, 2, "lat_rr0");
    push(0, 16'h0002, 16'h0000); send(0, 1'b0, 1'b0, 4'd0);
    wait_strb(0, 0, 16'hFFFF, 2, "lat_rr1");
    push(0, 16'h0004, 16'h0004); send(0, 1'b1, 1'b0, 4'd0);
    wait_strb(0, 0, 16'hFFFF, 2, "lat_rr2");
    @(negedge clk);
    check("sent_after_3", {24'h0, sent0}, 32'd3);
    check("sel_holds", {28'h0, sel0}, 32'd2);
    check("idle_busy", {31'h0, busy0}, 32'h0);

    // Pointer to 15 via lane 14, then wrap 15 -> 0 -> 15 with lane_en=8001
    lane_en_i[0] = 16'h4000;
    push(0, 16'h4000, 16'h0000); send(0, 1'b0, 1'b0, 4'd0);
    wait_strb(0, 0, 16'hFFFF, 2, "lat_l14");
    lane_en_i[0] = 16'h8001;
    push(0, 16'h8000, 16'h8000); send(0, 1'b1, 1'b0, 4'd0);
    wait_strb(0, 0, 16'hFFFF, 2, "lat_l15a");
    push(0, 16'h0001, 16'h0001); send(0, 1'b1, 1'b0, 4'd0);
    wait_strb(0, 0, 16'hFFFF, 2, "lat_l0");
    push(0, 16'h8000, 16'h0000); send(0, 1'b0, 1'b0, 4'd0);
    wait_strb(0, 0, 16'hFFFF, 2, "lat_l15b");

    // Fixed lane 9, not ready for 5 scan cycles; ptr stays at 0
    lane_en_i[0]    = 16'hFFFF;
    lane_ready_i[0] = 16'hFDFF;
    push(0, 16'h0200, 16'h0200); send(0, 1'b1, 1'b1, 4'd9);
    wait_strb(0, 5, 16'hFFFF, 7, "lat_fixed9");
    check("sel_fixed9", {28'h0, sel0}, 32'd9);
    push(0, 16'h0001, 16'h0000); send(0, 1'b0, 1'b0, 4'd0);
    wait_strb(0, 0, 16'hFFFF, 2, "lat_ptr_kept");
    @(negedge clk);
    check("sent_before_rst", {24'h0, sent0}, 32'd9);

    // Async reset in the middle of a delivery
    send(0, 1'b1, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    check("deliver_strb", {16'h0, strb0}, 32'h0002);
    rst = 1'b1;
    #1;
    check("async_strb", {16'h0, strb0}, 32'h0);
    check("async_y", {16'h0, y0}, 32'h0);
    check("async_busy", {31'h0, busy0}, 32'h0);
    check("async_sel", {28'h0, sel0}, 32'h0);
    check("async_sent", {24'h0, sent0}, 32'h0);
    check("async_drop", {24'h0, drop0}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    push(0, 16'h0001, 16'h0001); send(0, 1'b1, 1'b0, 4'd0);
    wait_strb(0, 0, 16'hFFFF, 2, "lat_after_rst");
    @(negedge clk);
    check("sent_after_rst", {24'h0, sent0}, 32'd1);

    // TIMEOUT=4: no lane ready -> drop after 4 scan cycles
    lane_ready_i[1] = 16'h0000;
    send(1, 1'b1, 1'b0, 4'd0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 4) begin
        check("to_busy_c4", {31'h0, busy1}, 32'h1);
        check("to_drop_c4", {30'h0, drop1}, 32'h0);
      end
      if (c == 5) begin
        check("to_busy_c5", {31'h0, busy1}, 32'h0);
        check("to_drop_c5", {30'h0, drop1}, 32'h1);
        check("to_sent_c5", {30'h0, sent1}, 32'h0);
      end
    end

    // Ready rising in the last scan cycle wins over the timeout
    push(1, 16'h0001, 16'h0001); send(1, 1'b1, 1'b0, 4'd0);
    wait_strb(1, 3, 16'hFFFF, 5, "lat_last_scan");
    @(negedge clk);
    check("last_scan_drop", {30'h0, drop1}, 32'h1);
    check("last_scan_sent", {30'h0, sent1}, 32'h1);

    // Four more deliveries -> sent_cnt saturates at 3
    push(1, 16'h0002, 16'h0000); send(1, 1'b0, 1'b0, 4'd0);
    wait_strb(1, 0, 16'hFFFF, 2, "lat_sat1");
    push(1, 16'h0004, 16'h0004); send(1, 1'b1, 1'b0, 4'd0);
    wait_strb(1, 0, 16'hFFFF, 2, "lat_sat2");
    push(1, 16'h0008, 16'h0000); send(1, 1'b0, 1'b0, 4'd0);
    wait_strb(1, 0, 16'hFFFF, 2, "lat_sat3");
    push(1, 16'h0010, 16'h0010); send(1, 1'b1, 1'b0, 4'd0);
    wait_strb(1, 0, 16'hFFFF, 2, "lat_sat4");
    @(negedge clk);
    check("sent_saturated", {30'h0, sent1}, 32'd3);

    // Three more timeouts -> drop_cnt saturates at 3
    lane_ready_i[1] = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      send(1, 1'b1, 1'b0, 4'd0);
      repeat (5) @(negedge clk);
    end
    check("drop_saturated", {30'h0, drop1}, 32'd3);

    // lane_en=0 -> in_valid ignored
    lane_en_i[1]    = 16'h0000;
    lane_ready_i[1] = 16'hFFFF;
    a_i[1]          = 1'b1;
    in_valid_i[1]   = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("no_en_ready", {31'h0, rdy1}, 32'h0);
      check("no_en_busy", {31'h0, busy1}, 32'h0);
    end
    in_valid_i[1] = 1'b0;
    lane_en_i[1]  = 16'hFFFF;
    @(negedge clk);
    check("en_restored_ready", {31'h0, rdy1}, 32'h1);
    check("no_en_sent", {30'h0, sent1}, 32'd3);

    @(negedge clk);
    check("q0_empty", q0.size(), 32'd0);
    check("q1_empty", q1.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
